// File: rtl/clint_ctrl.sv
// Core-local interruptor: prescaled mtime counter, mtimecmp compare, software
// interrupt bit and synchronized external request, merged into mip/enable outputs.
module clint_ctrl #(
    parameter int N        = 64,
    parameter int TICK_DIV = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         extIrq,
    input  logic         wrEnable,
    input  logic [1:0]   regSel,
    input  logic [N-1:0] wrData,
    output logic [N-1:0] rdData,
    input  logic         MIE,
    input  logic [15:0]  mieMask,
    output logic [15:0]  mip,
    output logic [15:0]  interruptSignal,
    output logic         async
);

    localparam logic [8:0] TICK_LAST = 9'(TICK_DIV - 1);

    localparam logic [1:0] SEL_MSIP     = 2'd0;
    localparam logic [1:0] SEL_MTIMECMP = 2'd1;
    localparam logic [1:0] SEL_MTIME    = 2'd2;

    logic [8:0]   presc_reg, presc_next;
    logic         tick;
    logic [N-1:0] mtime_reg, mtime_next;
    logic [N-1:0] mtimecmp_reg, mtimecmp_next;
    logic         msip_reg, msip_next;
    logic         sync1_reg;
    logic         meip_s;
    logic [15:0]  mip_reg, int_reg;
    logic         async_reg;

    logic         wr_msip, wr_mtimecmp, wr_mtime;
    logic         mtip;
    logic [15:0]  pend_raw;
    logic [15:0]  pend_en;

    assign wr_msip     = wrEnable && (regSel == SEL_MSIP);
    assign wr_mtimecmp = wrEnable && (regSel == SEL_MTIMECMP);
    assign wr_mtime    = wrEnable && (regSel == SEL_MTIME);

    // The prescaler keeps running through mtime writes; only reset restarts it.
    always_comb begin
        tick       = (presc_reg == TICK_LAST);
        presc_next = tick ? 9'd0 : presc_reg + 9'd1;
    end

    always_comb begin
        mtime_next    = mtime_reg;
        mtimecmp_next = mtimecmp_reg;
        msip_next     = msip_reg;
        if (wr_mtime) begin
            mtime_next = wrData;
        end else if (tick) begin
            mtime_next = mtime_reg + 1'b1;
        end
        if (wr_mtimecmp) begin
            mtimecmp_next = wrData;
        end
        if (wr_msip) begin
            msip_next = wrData[0];
        end
    end

    assign mtip = (mtime_reg >= mtimecmp_reg);

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_pend
            if (gi == 3) begin : g_msip
                assign pend_raw[gi] = msip_reg;
            end else if (gi == 7) begin : g_mtip
                assign pend_raw[gi] = mtip;
            end else if (gi == 11) begin : g_meip
                assign pend_raw[gi] = meip_s;
            end else begin : g_zero
                assign pend_raw[gi] = 1'b0;
            end
        end
    endgenerate

    assign pend_en = pend_raw & mieMask;

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_reg    <= 9'd0;
            mtime_reg    <= '0;
            mtimecmp_reg <= '1;
            msip_reg     <= 1'b0;
            sync1_reg    <= 1'b0;
            meip_s       <= 1'b0;
            mip_reg      <= 16'h0000;
            int_reg      <= 16'h0000;
            async_reg    <= 1'b0;
        end else begin
            presc_reg    <= presc_next;
            mtime_reg    <= mtime_next;
            mtimecmp_reg <= mtimecmp_next;
            msip_reg     <= msip_next;
            sync1_reg    <= extIrq;
            meip_s       <= sync1_reg;
            mip_reg      <= pend_raw;
            int_reg      <= pend_en;
            async_reg    <= MIE & (|pend_en);
        end
    end

    always_comb begin
        rdData = '0;
        case (regSel)
            SEL_MSIP:     rdData = {{(N-1){1'b0}}, msip_reg};
            SEL_MTIMECMP: rdData = mtimecmp_reg;
            SEL_MTIME:    rdData = mtime_reg;
            default:      rdData = '0;
        endcase
    end

    assign mip             = mip_reg;
    assign interruptSignal = int_reg;
    assign async           = async_reg;

endmodule

// File: tb/tb_clint_ctrl.sv
// Bench for clint_ctrl: one instance with TICK_DIV=4 and one with TICK_DIV=1
// share stimulus; expected values are queued per cycle and compared on sampling.
module tb_clint_ctrl;

    localparam int N = 64;
    localparam logic [N-1:0] ALL1 = {N{1'b1}};

    logic         clk = 1'b0;
    logic         reset;
    logic         extIrq;
    logic         wrEnable;
    logic [1:0]   regSel;
    logic [N-1:0] wrData;
    logic         MIE;
    logic [15:0]  mieMask;

    logic [N-1:0] rd4, rd1;
    logic [15:0]  mip4, mip1, int4, int1;
    logic         as4, as1;

    int vectors = 0;
    int miscompares = 0;
    logic [63:0] exp_q[$];
    logic [63:0] e;

    always #5 clk = ~clk;

    clint_ctrl #(.N(N), .TICK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .extIrq(extIrq), .wrEnable(wrEnable),
        .regSel(regSel), .wrData(wrData), .rdData(rd4), .MIE(MIE),
        .mieMask(mieMask), .mip(mip4), .interruptSignal(int4), .async(as4)
    );

    clint_ctrl #(.N(N), .TICK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .extIrq(extIrq), .wrEnable(wrEnable),
        .regSel(regSel), .wrData(wrData), .rdData(rd1), .MIE(MIE),
        .mieMask(mieMask), .mip(mip1), .interruptSignal(int1), .async(as1)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after the last reset edge with reset low (cycle 0).
    task automatic do_reset();
        reset = 1'b1; wrEnable = 1'b0; regSel = 2'd2; wrData = '0;
        extIrq = 1'b0; MIE = 1'b0; mieMask = 16'h0000;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; wrEnable = 1'b1; regSel = 2'd2; wrData = 64'h55;
        extIrq = 1'b0; MIE = 1'b1; mieMask = 16'hFFFF;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        step();
        step();
        e = exp_q.pop_front(); vectors++;
        if (rd4 !== e) begin miscompares++; $display("FAIL rst_mtime4 got %h exp %h", rd4, e); end
        else $display("vec rst_mtime4 ok %h", rd4);
        e = exp_q.pop_front(); vectors++;
        if (rd1 !== e) begin miscompares++; $display("FAIL rst_mtime1 got %h exp %h", rd1, e); end
        else $display("vec rst_mtime1 ok %h", rd1);
        exp_q.push_back(ALL1);
        regSel = 2'd1; #1;
        e = exp_q.pop_front(); vectors++;
        if (rd4 !== e) begin miscompares++; $display("FAIL rst_mtimecmp got %h exp %h", rd4, e); end
        else $display("vec rst_mtimecmp ok %h", rd4);
        exp_q.push_back(64'h0);
        regSel = 2'd0; #1;
        e = exp_q.pop_front(); vectors++;
        if (rd4 !== e) begin miscompares++; $display("FAIL rst_msip got %h exp %h", rd4, e); end
        else $display("vec rst_msip ok %h", rd4);
        exp_q.push_back(64'h0);
        regSel = 2'd3; #1;
        e = exp_q.pop_front(); vectors++;
        if (rd4 !== e) begin miscompares++; $display("FAIL rst_sel3 got %h exp %h", rd4, e); end
        else $display("vec rst_sel3 ok %h", rd4);
        exp_q.push_back(64'h0);
        e = exp_q.pop_front(); vectors++;
        if ({31'd0, as4, int4, mip4} !== e) begin
            miscompares++; $display("FAIL rst_outs got mip %h int %h async %b exp 0", mip4, int4, as4);
        end else $display("vec rst_outs ok");
        wrEnable = 1'b0;
    endtask

    task automatic test_prescaler();
        do_reset();
        regSel = 2'd2;
        for (int c = 1; c <= 8; c++) begin
            exp_q.push_back(64'(c / 4));
            exp_q.push_back(64'(c));
            step();
            e = exp_q.pop_front();
            if (c == 3 || c == 4 || c == 8) begin
                vectors++;
                if (rd4 !== e) begin miscompares++; $display("FAIL presc_mtime4_c%0d got %h exp %h", c, rd4, e); end
                else $display("vec presc_mtime4_c%0d ok %h", c, rd4);
            end
            e = exp_q.pop_front();
            if (c == 4 || c == 8) begin
                vectors++;
                if (rd1 !== e) begin miscompares++; $display("FAIL presc_mtime1_c%0d got %h exp %h", c, rd1, e); end
                else $display("vec presc_mtime1_c%0d ok %h", c, rd1);
            end
        end
        exp_q.push_back(64'h0);
        e = exp_q.pop_front(); vectors++;
        if ({47'd0, as4, mip4} !== e) begin
            miscompares++; $display("FAIL presc_idle got mip %h async %b exp 0", mip4, as4);
        end else $display("vec presc_idle ok");
    endtask

    task automatic test_timer_cmp();
        do_reset();
        mieMask = 16'h0080; MIE = 1'b1;
        wrEnable = 1'b1; regSel = 2'd1; wrData = 64'd5;
        for (int c = 1; c <= 33; c++) begin
            e = (c >= 21 && c <= 31) ? 64'h0080 : 64'h0;
            exp_q.push_back(e);
            exp_q.push_back(e);
            exp_q.push_back((e != 0) ? 64'h1 : 64'h0);
            step();
            if (c == 1 || c == 31) wrEnable = 1'b0;
            e = exp_q.pop_front(); vectors++;
            if ({48'd0, mip4} !== e) begin miscompares++; $display("FAIL cmp_mip_c%0d got %h exp %h", c, mip4, e[15:0]); end
            else $display("vec cmp_mip_c%0d ok %h", c, mip4);
            e = exp_q.pop_front(); vectors++;
            if ({48'd0, int4} !== e) begin miscompares++; $display("FAIL cmp_int_c%0d got %h exp %h", c, int4, e[15:0]); end
            e = exp_q.pop_front(); vectors++;
            if ({63'd0, as4} !== e) begin miscompares++; $display("FAIL cmp_async_c%0d got %b exp %b", c, as4, e[0]); end
            if (c == 30) begin wrEnable = 1'b1; regSel = 2'd1; wrData = ALL1; end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        wrEnable = 1'b1; regSel = 2'd2; wrData = ALL1;
        for (int c = 1; c <= 3; c++) begin
            exp_q.push_back((c == 1) ? ALL1 : 64'(c - 2));
            exp_q.push_back((c == 2) ? 64'h0080 : 64'h0);
            step();
            wrEnable = 1'b0;
            e = exp_q.pop_front(); vectors++;
            if (rd1 !== e) begin miscompares++; $display("FAIL wrap_mtime_c%0d got %h exp %h", c, rd1, e); end
            else $display("vec wrap_mtime_c%0d ok %h", c, rd1);
            e = exp_q.pop_front(); vectors++;
            if ({48'd0, mip1} !== e) begin miscompares++; $display("FAIL wrap_mip_c%0d got %h exp %h", c, mip1, e[15:0]); end
            else $display("vec wrap_mip_c%0d ok %h", c, mip1);
        end
    endtask

    task automatic test_msip();
        do_reset();
        mieMask = 16'h0008; MIE = 1'b0;
        wrEnable = 1'b1; regSel = 2'd0; wrData = ALL1;
        exp_q.push_back(64'h1);
        exp_q.push_back(64'h0);
        step();
        wrEnable = 1'b0;
        e = exp_q.pop_front(); vectors++;
        if (rd4 !== e) begin miscompares++; $display("FAIL msip_rd got %h exp %h", rd4, e); end
        else $display("vec msip_rd ok %h", rd4);
        e = exp_q.pop_front(); vectors++;
        if ({48'd0, mip4} !== e) begin miscompares++; $display("FAIL msip_mip_early got %h exp %h", mip4, e[15:0]); end
        exp_q.push_back({31'd0, 1'b0, 16'h0008, 16'h0008});
        step();
        e = exp_q.pop_front(); vectors++;
        if ({31'd0, as4, int4, mip4} !== e) begin
            miscompares++; $display("FAIL msip_pend got mip %h int %h async %b exp mip 0008 int 0008 async 0", mip4, int4, as4);
        end else $display("vec msip_pend ok");
        MIE = 1'b1;
        exp_q.push_back(64'h1);
        step();
        e = exp_q.pop_front(); vectors++;
        if ({63'd0, as4} !== e) begin miscompares++; $display("FAIL msip_async got %b exp 1", as4); end
        else $display("vec msip_async ok");
        mieMask = 16'hFFFF; wrEnable = 1'b1; regSel = 2'd3; wrData = 64'h0;
        exp_q.push_back(64'h0008);
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h1);
        step();
        wrEnable = 1'b0;
        e = exp_q.pop_front(); vectors++;
        if ({48'd0, int4} !== e) begin miscompares++; $display("FAIL mask_other got %h exp %h", int4, e[15:0]); end
        else $display("vec mask_other ok %h", int4);
        e = exp_q.pop_front(); vectors++;
        if (rd4 !== e) begin miscompares++; $display("FAIL sel3_rd got %h exp %h", rd4, e); end
        else $display("vec sel3_rd ok %h", rd4);
        regSel = 2'd0; #1;
        e = exp_q.pop_front(); vectors++;
        if (rd4 !== e) begin miscompares++; $display("FAIL sel3_nowrite got %h exp %h", rd4, e); end
        else $display("vec sel3_nowrite ok %h", rd4);
        wrEnable = 1'b1; wrData = 64'h0;
        exp_q.push_back(64'h0008);
        exp_q.push_back(64'h0);
        step();
        wrEnable = 1'b0;
        e = exp_q.pop_front(); vectors++;
        if ({48'd0, mip4} !== e) begin miscompares++; $display("FAIL msip_clr_lag got %h exp %h", mip4, e[15:0]); end
        step();
        e = exp_q.pop_front(); vectors++;
        if ({47'd0, as4, mip4} !== e) begin
            miscompares++; $display("FAIL msip_clr got mip %h async %b exp 0", mip4, as4);
        end else $display("vec msip_clr ok");
    endtask

    task automatic test_ext();
        do_reset();
        mieMask = 16'h0800; MIE = 1'b1;
        extIrq = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            e = (c >= 3 && c <= 7) ? 64'h0800 : 64'h0;
            exp_q.push_back(e);
            exp_q.push_back((e != 0) ? 64'h1 : 64'h0);
            step();
            e = exp_q.pop_front(); vectors++;
            if ({48'd0, mip4} !== e) begin miscompares++; $display("FAIL ext_mip_c%0d got %h exp %h", c, mip4, e[15:0]); end
            else $display("vec ext_mip_c%0d ok %h", c, mip4);
            e = exp_q.pop_front(); vectors++;
            if ({63'd0, as4} !== e) begin miscompares++; $display("FAIL ext_async_c%0d got %b exp %b", c, as4, e[0]); end
            if (c == 5) extIrq = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mieMask = 16'hFFFF; MIE = 1'b1;
        wrEnable = 1'b1; regSel = 2'd2; wrData = 64'h10;
        exp_q.push_back(64'h10);
        step();
        wrEnable = 1'b0;
        e = exp_q.pop_front(); vectors++;
        if (rd1 !== e) begin miscompares++; $display("FAIL wr_vs_tick got %h exp %h", rd1, e); end
        else $display("vec wr_vs_tick ok %h", rd1);
        exp_q.push_back(64'h11);
        exp_q.push_back(64'h10);
        step();
        e = exp_q.pop_front(); vectors++;
        if (rd1 !== e) begin miscompares++; $display("FAIL after_wr1 got %h exp %h", rd1, e); end
        e = exp_q.pop_front(); vectors++;
        if (rd4 !== e) begin miscompares++; $display("FAIL after_wr4 got %h exp %h", rd4, e); end
        reset = 1'b1; wrEnable = 1'b1; wrData = 64'h99;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        exp_q.push_back(ALL1);
        exp_q.push_back(64'h0);
        step();
        reset = 1'b0; wrEnable = 1'b0;
        e = exp_q.pop_front(); vectors++;
        if (rd1 !== e) begin miscompares++; $display("FAIL rst_wins1 got %h exp %h", rd1, e); end
        else $display("vec rst_wins1 ok %h", rd1);
        e = exp_q.pop_front(); vectors++;
        if (rd4 !== e) begin miscompares++; $display("FAIL rst_wins4 got %h exp %h", rd4, e); end
        regSel = 2'd1; #1;
        e = exp_q.pop_front(); vectors++;
        if (rd1 !== e) begin miscompares++; $display("FAIL rst_cmp got %h exp %h", rd1, e); end
        e = exp_q.pop_front(); vectors++;
        if ({31'd0, as1, int1, mip1} !== e) begin
            miscompares++; $display("FAIL rst_outs2 got mip %h int %h async %b exp 0", mip1, int1, as1);
        end else $display("vec rst_outs2 ok");
        regSel = 2'd2;
        for (int c = 4; c <= 7; c++) begin
            exp_q.push_back((c == 7) ? 64'h1 : 64'h0);
            step();
            e = exp_q.pop_front();
            if (c >= 6) begin
                vectors++;
                if (rd4 !== e) begin miscompares++; $display("FAIL presc_restart_c%0d got %h exp %h", c, rd4, e); end
                else $display("vec presc_restart_c%0d ok %h", c, rd4);
            end
        end
    endtask

    initial begin
        reset = 1'b1; extIrq = 1'b0; wrEnable = 1'b0; regSel = 2'd0;
        wrData = '0; MIE = 1'b0; mieMask = 16'h0000;
        test_reset();
        test_prescaler();
        test_timer_cmp();
        test_wrap();
        test_msip();
        test_ext();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
